bus_watchdog: RTL and testbench

BUS_WATCHDOG -- requirements
Module: bus_watchdog

---
 rtl/bus_watchdog_pkg.sv | 19 +
 rtl/bus_watchdog_sync_ff.sv | 24 ++
 rtl/bus_watchdog.sv | 148 ++++++++++++++
 tb/tb_bus_watchdog.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_watchdog_pkg.sv
// Shared definitions for the bus watchdog: FSM state encoding, counter width
// and the saturation limit of the fault counter.
package bus_watchdog_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        ERROR   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Width of the cycle counter that tracks an outstanding bus cycle.
    localparam int unsigned CNT_W = 16;

    // Width and saturation value of the timeout counter.
    localparam int unsigned FAULT_COUNT_W   = 8;
    localparam int unsigned FAULT_COUNT_MAX = 255;

endpackage

// File: rtl/bus_watchdog_sync_ff.sv
// Single-bit flop chain synchronizer with synchronous active-high reset.
module sync_ff #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    // Shift the asynchronous input through DEPTH flops; reset clears the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/bus_watchdog.sv
// Bus watchdog: times an outstanding CPU bus cycle (address strobe without
// DTACK) and raises BUS_ERROR after TIMEOUT_CYCLES. Optional fault log is
// enabled by defining BUS_WATCHDOG_FAULT_LOG_EN; without it the FAULT_*
// outputs are tied to zero and CLEAR_IN is ignored.
module bus_watchdog
    import bus_watchdog_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic        MCLK_IN,
    input  logic        RESET_IN,
    input  logic        AS_IN,
    input  logic        DTACK_IN,
    input  logic        STEPEN_IN,
    input  logic [23:0] ADDR_IN,
    input  logic        WR_IN,
    input  logic [2:0]  STATUS_CODE_IN,
    input  logic        CLEAR_IN,
    output logic        BUS_ERROR,
    output logic        FAULT_VALID,
    output logic [23:0] FAULT_ADDR,
    output logic        FAULT_WR,
    output logic [2:0]  FAULT_FC,
    output logic [7:0]  FAULT_COUNT
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             as_s;
    logic             as_d;
    logic             as_rise;
    logic             err_entry;

    sync_ff #(
        .DEPTH(SYNC_STAGES)
    ) u_as_sync (
        .clk(MCLK_IN),
        .rst(RESET_IN),
        .d  (AS_IN),
        .q  (as_s)
    );

    // Rising edge of the synchronized strobe; as_d resets low so a strobe
    // already high at reset release still counts as a new edge.
    assign as_rise = as_s & ~as_d;

    // Terminal count reached this cycle with nothing aborting or freezing it.
    always_comb begin
        err_entry = 1'b0;
        if (state == COUNT && as_s && !DTACK_IN && !STEPEN_IN && cnt == TERM_CNT) begin
            err_entry = 1'b1;
        end
    end

    // Watchdog FSM with cycle counter and registered BUS_ERROR.
    always_ff @(posedge MCLK_IN) begin
        if (RESET_IN) begin
            state     <= IDLE;
            cnt       <= '0;
            as_d      <= 1'b0;
            BUS_ERROR <= 1'b0;
        end else begin
            as_d <= as_s;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (as_rise) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (DTACK_IN || !as_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (err_entry) begin
                        state     <= ERROR;
                        cnt       <= '0;
                        BUS_ERROR <= 1'b1;
                    end else if (!STEPEN_IN) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERROR: begin
                    if (!as_s) begin
                        state     <= RELEASE;
                        BUS_ERROR <= 1'b0;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    BUS_ERROR <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_WATCHDOG_FAULT_LOG_EN
    // Fault log: first fault wins, saturating timeout count; a clear that
    // coincides with a new fault still records that fault with count 1.
    always_ff @(posedge MCLK_IN) begin
        if (RESET_IN) begin
            FAULT_VALID <= 1'b0;
            FAULT_ADDR  <= '0;
            FAULT_WR    <= 1'b0;
            FAULT_FC    <= '0;
            FAULT_COUNT <= '0;
        end else begin
            if (CLEAR_IN) begin
                FAULT_VALID <= 1'b0;
                FAULT_ADDR  <= '0;
                FAULT_WR    <= 1'b0;
                FAULT_FC    <= '0;
                FAULT_COUNT <= '0;
            end
            if (err_entry) begin
                if (!FAULT_VALID || CLEAR_IN) begin
                    FAULT_VALID <= 1'b1;
                    FAULT_ADDR  <= ADDR_IN;
                    FAULT_WR    <= WR_IN;
                    FAULT_FC    <= STATUS_CODE_IN;
                end
                if (CLEAR_IN) begin
                    FAULT_COUNT <= 8'd1;
                end else if (FAULT_COUNT != FAULT_COUNT_W'(FAULT_COUNT_MAX)) begin
                    FAULT_COUNT <= FAULT_COUNT + 1'b1;
                end
            end
        end
    end
`else
    logic unused_log_inputs;
    assign unused_log_inputs = ^{CLEAR_IN, ADDR_IN, WR_IN, STATUS_CODE_IN, err_entry};

    assign FAULT_VALID = 1'b0;
    assign FAULT_ADDR  = '0;
    assign FAULT_WR    = 1'b0;
    assign FAULT_FC    = '0;
    assign FAULT_COUNT = '0;
`endif

endmodule

// File: tb/tb_bus_watchdog.sv
// Self-checking bench for bus_watchdog (TIMEOUT_CYCLES=8, SYNC_STAGES=2):
// directed bus cycles followed by random stimulus, every cycle compared with
// a behavioural timeout model.
module tb_bus_watchdog;
    import bus_watchdog_pkg::*;

    localparam int T = 8;
`ifdef BUS_WATCHDOG_FAULT_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, as_in, dtack, stepen, wr, clr;
    logic [23:0] addr;
    logic [2:0]  fc;
    logic        berr, fvalid, fwr;
    logic [23:0] faddr;
    logic [2:0]  ffc;
    logic [7:0]  fcount;

    always #5 clk = ~clk;

    bus_watchdog #(
        .TIMEOUT_CYCLES(T),
        .SYNC_STAGES   (2)
    ) dut (
        .MCLK_IN       (clk),
        .RESET_IN      (rst),
        .AS_IN         (as_in),
        .DTACK_IN      (dtack),
        .STEPEN_IN     (stepen),
        .ADDR_IN       (addr),
        .WR_IN         (wr),
        .STATUS_CODE_IN(fc),
        .CLEAR_IN      (clr),
        .BUS_ERROR     (berr),
        .FAULT_VALID   (fvalid),
        .FAULT_ADDR    (faddr),
        .FAULT_WR      (fwr),
        .FAULT_FC      (ffc),
        .FAULT_COUNT   (fcount)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: strobe delay line, "transaction pending" timer,
    // error flag, one-cycle cool-down, and a first-fault log.
    bit    m_sync [2];
    bit    m_prev;
    bit    m_pending, m_berr, m_cool;
    int    m_elapsed;
    bit    m_valid, m_wr;
    int    m_addr, m_fc, m_count;

    task automatic model_edge();
        bit s_old, p_old, entry;
        entry = 1'b0;
        if (rst) begin
            m_sync[0] = 0; m_sync[1] = 0; m_prev = 0;
            m_pending = 0; m_berr = 0; m_cool = 0; m_elapsed = 0;
            m_valid = 0; m_wr = 0; m_addr = 0; m_fc = 0; m_count = 0;
            return;
        end
        s_old = m_sync[1];
        p_old = m_prev;
        if (m_cool) begin
            m_cool = 0;
        end else if (m_berr) begin
            if (!s_old) begin
                m_berr = 0;
                m_cool = 1;
            end
        end else if (m_pending) begin
            if (dtack || !s_old) begin
                m_pending = 0;
                m_elapsed = 0;
            end else if (!stepen) begin
                if (m_elapsed == T - 1) begin
                    m_pending = 0;
                    m_berr    = 1;
                    entry     = 1;
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                end
            end
        end else if (s_old && !p_old) begin
            m_pending = 1;
            m_elapsed = 0;
        end
        if (clr) begin
            m_valid = 0; m_wr = 0; m_addr = 0; m_fc = 0; m_count = 0;
        end
        if (entry) begin
            if (!m_valid) begin
                m_valid = 1; m_addr = int'(addr); m_wr = wr; m_fc = int'(fc);
            end
            m_count = (m_count < 255) ? m_count + 1 : 255;
        end
        m_prev    = s_old;
        m_sync[1] = m_sync[0];
        m_sync[0] = as_in;
    endtask

    task automatic compare_all();
        check_eq("bus_error",   32'(berr),   32'(m_berr));
        check_eq("fault_valid", 32'(fvalid), LOG_EN ? 32'(m_valid) : 32'd0);
        check_eq("fault_addr",  32'(faddr),  LOG_EN ? 32'(m_addr)  : 32'd0);
        check_eq("fault_wr",    32'(fwr),    LOG_EN ? 32'(m_wr)    : 32'd0);
        check_eq("fault_fc",    32'(ffc),    LOG_EN ? 32'(m_fc)    : 32'd0);
        check_eq("fault_count", 32'(fcount), LOG_EN ? 32'(m_count) : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    // One bus cycle: strobe held until BUS_ERROR or the cycle budget runs out.
    // Cycle 0 is the first cycle the synchronized strobe is high; rise is the
    // cycle in which BUS_ERROR is first seen high, -1 if never.
    task automatic txn(input logic [23:0] a, input logic [2:0] f, input logic w,
                       input int dtack_at, input int step_at, input int step_len,
                       input int clr_at, output int rise);
        addr  = a;
        fc    = f;
        wr    = w;
        as_in = 1'b1;
        rise  = -1;
        tick();
        tick();
        for (int k = 0; k < 40; k++) begin
            if (berr) begin
                rise = k;
                break;
            end
            dtack  = (k == dtack_at);
            stepen = (k >= step_at) && (k < step_at + step_len);
            clr    = (k == clr_at);
            tick();
        end
        dtack  = 1'b0;
        stepen = 1'b0;
        clr    = 1'b0;
        as_in  = 1'b0;
        for (int k = 0; k < 6; k++) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int r;
        int n;
        rst = 1'b1; as_in = 1'b0; dtack = 1'b0; stepen = 1'b0;
        wr = 1'b0; clr = 1'b0; addr = '0; fc = '0;
        tick();
        tick();
        check_eq("reset_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        tick();

        // DTACK three cycles into the bus cycle: no error, back to IDLE.
        txn(24'h123456, 3'd2, 1'b1, 3, -1, 0, -1, r);
        check_eq("dtack_early_rise", 32'(r), 32'hFFFF_FFFF);
        check_eq("dtack_early_idle", 32'(dut.state), 32'(IDLE));

        // Plain timeout: BUS_ERROR in cycle T+1 and first fault logged.
        txn(24'hFFF000, 3'd5, 1'b0, -1, -1, 0, -1, r);
        check_eq("timeout_latency", 32'(r), 32'(T + 1));
        check_eq("log1_addr",  32'(faddr),  LOG_EN ? 32'h00FF_F000 : 32'd0);
        check_eq("log1_fc",    32'(ffc),    LOG_EN ? 32'd5 : 32'd0);
        check_eq("log1_wr",    32'(fwr),    32'd0);
        check_eq("log1_count", 32'(fcount), LOG_EN ? 32'd1 : 32'd0);

        // DTACK exactly on the terminal-count cycle wins.
        txn(24'h0ABCDE, 3'd1, 1'b1, T, -1, 0, -1, r);
        check_eq("dtack_term_rise",  32'(r), 32'hFFFF_FFFF);
        check_eq("dtack_term_count", 32'(fcount), LOG_EN ? 32'd1 : 32'd0);

        // Second timeout keeps the first logged address.
        txn(24'h000100, 3'd3, 1'b1, -1, -1, 0, -1, r);
        check_eq("timeout2_latency", 32'(r), 32'(T + 1));
        check_eq("log2_addr",  32'(faddr),  LOG_EN ? 32'h00FF_F000 : 32'd0);
        check_eq("log2_count", 32'(fcount), LOG_EN ? 32'd2 : 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_eq("clear_valid", 32'(fvalid), 32'd0);
        check_eq("clear_addr",  32'(faddr),  32'd0);
        check_eq("clear_count", 32'(fcount), 32'd0);

        // Single-step freeze of 20 cycles delays the error by 20.
        txn(24'h222222, 3'd6, 1'b0, -1, 3, 20, -1, r);
        check_eq("step_latency", 32'(r), 32'(T + 1 + 20));
        check_eq("step_log_addr", 32'(faddr), LOG_EN ? 32'h0022_2222 : 32'd0);

        // Saturate the timeout counter.
        for (int i = 0; i < 258; i++) begin
            txn(24'(i), 3'(i), 1'(i), -1, -1, 0, -1, r);
        end
        check_eq("count_saturated", 32'(fcount), LOG_EN ? 32'd255 : 32'd0);

        // Clear coinciding with a new fault: new fault logged, count 1.
        txn(24'h0DEAD0, 3'd4, 1'b1, -1, -1, 0, T, r);
        check_eq("clr_entry_addr",  32'(faddr),  LOG_EN ? 32'h000D_EAD0 : 32'd0);
        check_eq("clr_entry_count", 32'(fcount), LOG_EN ? 32'd1 : 32'd0);

        // Reset while in ERROR, strobe still high afterwards.
        addr = 24'h345678; fc = 3'd7; wr = 1'b0; as_in = 1'b1;
        n = 0;
        while (!berr && n < 40) begin
            tick();
            n++;
        end
        check_eq("pre_reset_berr", 32'(berr), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("post_reset_berr",  32'(berr),   32'd0);
        check_eq("post_reset_state", 32'(dut.state), 32'(IDLE));
        check_eq("post_reset_valid", 32'(fvalid), 32'd0);
        check_eq("post_reset_count", 32'(fcount), 32'd0);
        n = 0;
        while (!berr && n < 40) begin
            tick();
            n++;
        end
        check_eq("held_as_after_reset", 32'(n), 32'(T + 3));
        as_in = 1'b0;
        for (int k = 0; k < 6; k++) tick();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 499) == 0);
            clr    = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 23) == 0) as_in = ~as_in;
            dtack  = ($urandom_range(0, 19) == 0);
            stepen = ($urandom_range(0, 5) == 0);
            addr   = 24'($urandom);
            wr     = 1'($urandom);
            fc     = 3'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
